// File: rtl/dmi_jtag_dr_ctrl.sv
// DTMCS/DMI data-register controller for the JTAG debug transport, TCK domain only.
// Issues DMI requests on Update-DR, re-issues BUSY answers and aborts hung requests.
module dmi_jtag_dr_ctrl #(
  parameter int unsigned AbitsWidth    = 7,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MaxRetries    = 2,
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [2:0]  IdleHint      = 3'd1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  capture_i,
  input  logic                  shift_i,
  input  logic                  update_i,
  input  logic                  tdi_i,
  input  logic                  dtmcs_select_i,
  input  logic                  dmi_select_i,
  output logic                  dtmcs_tdo_o,
  output logic                  dmi_tdo_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [AbitsWidth-1:0] req_addr_o,
  output logic [DataWidth-1:0]  req_data_o,
  output logic [1:0]            req_op_o,
  input  logic                  resp_valid_i,
  output logic                  resp_ready_o,
  input  logic [DataWidth-1:0]  resp_data_i,
  input  logic [1:0]            resp_resp_i,
  output logic                  dmi_hard_reset_o
);
  // state | meaning
  // IDLE  | no request outstanding, DR updates may start one
  // REQ   | request presented, waiting for req_ready_i
  // WAIT  | request accepted, waiting for a response or timeout
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam int unsigned W  = AbitsWidth + DataWidth + 2;
  localparam int unsigned RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MaxRetries);
  localparam logic [TW-1:0] TO_LAST   = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] ERR_FAIL = 2'd2;
  localparam logic [1:0] ERR_BUSY = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            error_q, error_d;
  logic [1:0]            op_q, op_d;
  logic [AbitsWidth-1:0] address_q, address_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic [W-1:0]          dr_q, dr_d;
  logic [31:0]           dtmcs_q, dtmcs_d;
  logic [RW-1:0]         retry_cnt_q, retry_cnt_d;
  logic [TW-1:0]         timeout_cnt_q, timeout_cnt_d;
  logic                  drop_pending_q, drop_pending_d;

  logic hard_reset, clr, busy, fail, rd_active;
  logic [1:0] dr_op;

  assign hard_reset = update_i & dtmcs_select_i & dtmcs_q[17] & ~rst_i;
  assign clr        = clear_i | hard_reset;
  assign rd_active  = (state_q != IDLE) && (op_q == OP_READ);
  assign dr_op      = dr_q[1:0];

  always_comb begin
    state_d        = state_q;
    error_d        = error_q;
    op_d           = op_q;
    address_d      = address_q;
    data_d         = data_q;
    dr_d           = dr_q;
    dtmcs_d        = dtmcs_q;
    retry_cnt_d    = retry_cnt_q;
    timeout_cnt_d  = timeout_cnt_q;
    drop_pending_d = drop_pending_q;
    busy           = 1'b0;
    fail           = 1'b0;

    if (capture_i && dtmcs_select_i) begin
      dtmcs_d = {14'd0, 3'b000, IdleHint, error_q, 6'(AbitsWidth), 4'd1};
    end else if (shift_i && dtmcs_select_i) begin
      dtmcs_d = {tdi_i, dtmcs_q[31:1]};
    end

    if (capture_i && dmi_select_i) begin
      busy = rd_active;
      dr_d = {address_q, data_q, (busy || error_q == ERR_BUSY) ? ERR_BUSY : error_q};
    end else if (shift_i && dmi_select_i) begin
      dr_d = {tdi_i, dr_q[W-1:1]};
    end

    if (update_i && dmi_select_i) begin
      if (state_q != IDLE || drop_pending_q) begin
        busy = 1'b1;
      end else if (error_q == 2'd0) begin
        address_d = dr_q[W-1 -: AbitsWidth];
        data_d    = dr_q[DataWidth+1:2];
        if (dr_op == OP_READ || dr_op == OP_WRITE) begin
          op_d        = dr_op;
          retry_cnt_d = '0;
          state_d     = REQ;
        end
      end
    end

    // A response after a timeout belongs to the aborted request and is dropped.
    if (drop_pending_q && resp_valid_i) drop_pending_d = 1'b0;

    case (state_q)
      REQ: begin
        if (req_ready_i) begin
          state_d       = WAIT;
          timeout_cnt_d = '0;
        end
      end
      WAIT: begin
        if (resp_valid_i) begin
          state_d = IDLE;
          case (resp_resp_i)
            2'd0: if (op_q == OP_READ) data_d = resp_data_i;
            2'd1: if (op_q == OP_READ) data_d = DataWidth'(32'hBAAD_C0DE);
            2'd2: begin
              fail = 1'b1;
              if (op_q == OP_READ) data_d = DataWidth'(32'hDEAD_BEEF);
            end
            default: begin
              if (retry_cnt_q < RETRY_MAX) begin
                retry_cnt_d = retry_cnt_q + RW'(1);
                state_d     = REQ;
              end else begin
                busy = 1'b1;
                if (op_q == OP_READ) data_d = DataWidth'(32'hB051_B051);
              end
            end
          endcase
        end else if (TimeoutCycles != 0 && timeout_cnt_q == TO_LAST) begin
          fail           = 1'b1;
          drop_pending_d = 1'b1;
          state_d        = IDLE;
        end else begin
          timeout_cnt_d = timeout_cnt_q + TW'(1);
        end
      end
      default: ;
    endcase

    if (error_q == 2'd0) begin
      if (fail)      error_d = ERR_FAIL;
      else if (busy) error_d = ERR_BUSY;
    end
    if (update_i && dtmcs_select_i && dtmcs_q[16]) error_d = 2'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      error_q        <= '0;
      op_q           <= '0;
      address_q      <= '0;
      data_q         <= '0;
      dr_q           <= '0;
      dtmcs_q        <= '0;
      retry_cnt_q    <= '0;
      timeout_cnt_q  <= '0;
      drop_pending_q <= 1'b0;
    end else begin
      dtmcs_q <= dtmcs_d;
      if (clr) begin
        state_q        <= IDLE;
        error_q        <= '0;
        op_q           <= '0;
        address_q      <= '0;
        data_q         <= '0;
        dr_q           <= '0;
        retry_cnt_q    <= '0;
        timeout_cnt_q  <= '0;
        drop_pending_q <= 1'b0;
      end else begin
        state_q        <= state_d;
        error_q        <= error_d;
        op_q           <= op_d;
        address_q      <= address_d;
        data_q         <= data_d;
        dr_q           <= dr_d;
        retry_cnt_q    <= retry_cnt_d;
        timeout_cnt_q  <= timeout_cnt_d;
        drop_pending_q <= drop_pending_d;
      end
    end
  end

  assign req_valid_o      = (state_q == REQ) & ~clr & ~rst_i;
  assign req_addr_o       = address_q;
  assign req_data_o       = data_q;
  assign req_op_o         = op_q;
  assign resp_ready_o     = 1'b1;
  assign dmi_hard_reset_o = hard_reset;
  assign dtmcs_tdo_o      = dtmcs_q[0] & ~rst_i;
  assign dmi_tdo_o        = dr_q[0] & ~rst_i;
endmodule
